// File: rtl/ama_riscv_mem_arb_pkg.sv
// Shared types for the imem/dmem memory arbiter: FSM states, grant owner and
// streak counter width.
package ama_riscv_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT_I = 2'd1,
    ARB_WAIT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_t;

  // Wide enough for any STARVE_MAX in 1..15.
  localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/ama_riscv_arb_pick.sv
// Combinational priority picker: dmem wins unless imem has been starved for
// STARVE_MAX grants; a stalled request keeps its held owner.
module ama_riscv_arb_pick
  import ama_riscv_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                imem_valid_i,
  input  logic                dmem_valid_i,
  input  logic [STREAK_W-1:0] streak_i,
  input  logic                lock_i,
  input  logic                held_owner_i,
  output logic                owner_o
);

  logic starved;

  assign starved = imem_valid_i && (streak_i == STREAK_W'(STARVE_MAX));

  always_comb begin
    owner_o = ARB_OWN_I;
    if (lock_i) begin
      owner_o = held_owner_i;
    end else if (dmem_valid_i && !starved) begin
      owner_o = ARB_OWN_D;
    end
  end

endmodule

// File: rtl/ama_riscv_mem_arb.sv
// Shares one memory port between fetch (imem) and load/store (dmem), one
// transaction in flight, responses routed back to the issuing requester.
module ama_riscv_mem_arb
  import ama_riscv_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_req_valid,
  output logic                imem_req_ready,
  input  logic [ADDR_W-1:0]   imem_req_addr,
  output logic                imem_rsp_valid,
  input  logic                imem_rsp_ready,
  output logic [DATA_W-1:0]   imem_rsp_data,
  input  logic                dmem_req_valid,
  output logic                dmem_req_ready,
  input  logic [ADDR_W-1:0]   dmem_req_addr,
  input  logic                dmem_req_we,
  input  logic [DATA_W-1:0]   dmem_req_wdata,
  input  logic [DATA_W/8-1:0] dmem_req_wstrb,
  output logic                dmem_rsp_valid,
  input  logic                dmem_rsp_ready,
  output logic [DATA_W-1:0]   dmem_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  arb_state_t          state_q, state_d;
  arb_owner_t          held_q, held_d;
  logic                lock_q, lock_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                pick;
  arb_owner_t          grant;
  logic                req_hs;

  ama_riscv_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .imem_valid_i (imem_req_valid),
    .dmem_valid_i (dmem_req_valid),
    .streak_i     (streak_q),
    .lock_i       (lock_q),
    .held_owner_i (held_q),
    .owner_o      (pick)
  );

  assign grant = arb_owner_t'(pick);

  // NOTE: always_comb uses blocking '=' and assigns every output a default
  // first so no path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d        = state_q;
    held_d         = held_q;
    lock_d         = lock_q;
    streak_d       = streak_q;
    req_hs         = 1'b0;
    mem_req_valid  = 1'b0;
    imem_req_ready = 1'b0;
    dmem_req_ready = 1'b0;
    mem_rsp_ready  = 1'b0;
    imem_rsp_valid = 1'b0;
    dmem_rsp_valid = 1'b0;
    imem_rsp_data  = mem_rsp_data;
    dmem_rsp_data  = mem_rsp_data;

    if (grant == ARB_OWN_D) begin
      mem_req_addr  = dmem_req_addr;
      mem_req_we    = dmem_req_we;
      mem_req_wdata = dmem_req_wdata;
      mem_req_wstrb = dmem_req_wstrb;
    end else begin
      mem_req_addr  = imem_req_addr;
      mem_req_we    = 1'b0;
      mem_req_wdata = '0;
      mem_req_wstrb = '0;
    end

    unique case (state_q)
      ARB_IDLE: begin
        mem_req_valid  = imem_req_valid || dmem_req_valid;
        imem_req_ready = (grant == ARB_OWN_I) && mem_req_ready;
        dmem_req_ready = (grant == ARB_OWN_D) && mem_req_ready;
        req_hs         = mem_req_valid && mem_req_ready;
        if (req_hs) begin
          lock_d  = 1'b0;
          state_d = (grant == ARB_OWN_D) ? ARB_WAIT_D : ARB_WAIT_I;
        end else if (mem_req_valid) begin
          // Stalled: freeze the owner until the downstream accepts.
          lock_d = 1'b1;
          held_d = grant;
        end
      end
      ARB_WAIT_I: begin
        mem_rsp_ready  = imem_rsp_ready;
        imem_rsp_valid = mem_rsp_valid;
        if (mem_rsp_valid && imem_rsp_ready) state_d = ARB_IDLE;
      end
      ARB_WAIT_D: begin
        mem_rsp_ready  = dmem_rsp_ready;
        dmem_rsp_valid = mem_rsp_valid;
        if (mem_rsp_valid && dmem_rsp_ready) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (!imem_req_valid || (req_hs && grant == ARB_OWN_I)) begin
      streak_d = '0;
    end else if (req_hs && grant == ARB_OWN_D &&
                 streak_q < STREAK_W'(STARVE_MAX)) begin
      streak_d = streak_q + 1'b1;
    end

    // Handshake outputs stay quiet for the whole reset cycle, including a
    // late downstream response to a dropped transaction.
    if (!rst) begin
      mem_req_valid  = 1'b0;
      imem_req_ready = 1'b0;
      dmem_req_ready = 1'b0;
      mem_rsp_ready  = 1'b0;
      imem_rsp_valid = 1'b0;
      dmem_rsp_valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      held_q   <= ARB_OWN_I;
      lock_q   <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      lock_q   <= lock_d;
      streak_q <= streak_d;
    end
  end

  a_no_rsp_in_idle: assert property (@(posedge clk) disable iff (!rst)
    !(state_q == ARB_IDLE && mem_rsp_valid))
    else $error("mem_rsp_valid seen with no transaction in flight");

endmodule
